// File: rtl/reg_store_ctrl.sv
// Store sequencer: captures A/B and a base address, then writes A to base and B to base+1.
// Optional ready-wait abort is built when STORE_TIMEOUT_EN is defined.
module reg_store_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              store_a,
    input  logic              store_b,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              datamem_ready,
    output logic              datamem_we,
    output logic [ADDR_W-1:0] datamem_addr,
    output logic [DATA_W-1:0] datamem_in,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] b_q;
    logic [ADDR_W-1:0] base_q;
    logic              sb_q;
    logic              abort_s;

    if (MAX_WAIT < 1) begin : g_max_wait_chk
        $error("MAX_WAIT must be at least 1");
    end

`ifdef STORE_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_q;
    logic              in_wr_s;

    assign in_wr_s = (state_q == WR_A) || (state_q == WR_B);
    // A handshake on the abort edge still wins over the abort.
    assign abort_s = in_wr_s && !datamem_ready && (wait_q == WAIT_W'(MAX_WAIT));

    // Wait counter: counts stalled cycles in a write state, cleared everywhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
        end else if (in_wr_s && !datamem_ready && !abort_s) begin
            wait_q <= wait_q + WAIT_W'(1);
        end else begin
            wait_q <= '0;
        end
    end

    // Error pulse, coincident with the done pulse of an aborted command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= abort_s;
        end
    end
`else
    assign abort_s = 1'b0;
    assign err     = 1'b0;
`endif

    // Command FSM with registered memory-port and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            datamem_we   <= 1'b0;
            datamem_addr <= '0;
            datamem_in   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            b_q          <= '0;
            base_q       <= '0;
            sb_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        b_q    <= B;
                        base_q <= base_addr;
                        sb_q   <= store_b;
                        busy   <= 1'b1;
                        if (store_a) begin
                            state_q      <= WR_A;
                            datamem_we   <= 1'b1;
                            datamem_addr <= base_addr;
                            datamem_in   <= A;
                        end else if (store_b) begin
                            state_q      <= WR_B;
                            datamem_we   <= 1'b1;
                            datamem_addr <= base_addr + ADDR_W'(1);
                            datamem_in   <= B;
                        end else begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                WR_A: begin
                    if (datamem_ready) begin
                        if (sb_q) begin
                            state_q      <= WR_B;
                            datamem_addr <= base_q + ADDR_W'(1);
                            datamem_in   <= b_q;
                        end else begin
                            state_q    <= DONE;
                            datamem_we <= 1'b0;
                            done       <= 1'b1;
                        end
                    end else if (abort_s) begin
                        state_q    <= DONE;
                        datamem_we <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                WR_B: begin
                    if (datamem_ready || abort_s) begin
                        state_q    <= DONE;
                        datamem_we <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    datamem_we <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_store_ctrl.sv
// Scoreboard bench for reg_store_ctrl: expected writes/done pulses are queued by
// the stimulus and consumed by a negedge monitor.
module tb_reg_store_ctrl;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 8;
    localparam int MAX_WAIT = 15;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              store_a;
    logic              store_b;
    logic [ADDR_W-1:0] base_addr;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              datamem_ready;
    logic              datamem_we;
    logic [ADDR_W-1:0] datamem_addr;
    logic [DATA_W-1:0] datamem_in;
    logic              busy;
    logic              done;
    logic              err;

    int   checks = 0;
    int   errors = 0;
    wr_t  wr_q[$];
    logic done_q[$];
    wr_t  mon_w;
    logic mon_e;
    bit   mon_en = 1'b0;
    int   nb, nd, nw;

    reg_store_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .start(start), .store_a(store_a), .store_b(store_b),
        .base_addr(base_addr), .A(A), .B(B), .datamem_ready(datamem_ready),
        .datamem_we(datamem_we), .datamem_addr(datamem_addr), .datamem_in(datamem_in),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    // Monitor: a write completes when we and ready are both high before an edge.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (datamem_we && datamem_ready) begin
                if (wr_q.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    mon_w = wr_q.pop_front();
                    check("wr_addr", 32'(datamem_addr), 32'(mon_w.addr));
                    check("wr_data", 32'(datamem_in), 32'(mon_w.data));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    mon_e = done_q.pop_front();
                    check("done_err", 32'(err), 32'(mon_e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sa, input logic sb, input logic [ADDR_W-1:0] base,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        tick();
        store_a = sa; store_b = sb; base_addr = base; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic watch(input int n, output int b, output int d, output int w);
        b = 0; d = 0; w = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy) b++;
            if (done) d++;
            if (datamem_we) w++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; store_a = 1'b0; store_b = 1'b0;
        base_addr = '0; A = '0; B = '0; datamem_ready = 1'b0;
        #1;
        check("reset_outputs", 32'({datamem_we, datamem_addr, busy, done, err}), 32'(0));
        check("reset_data", 32'(datamem_in), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;

        // Two-word store, ready tied high.
        datamem_ready = 1'b1;
        wr_q.push_back('{addr: 8'h10, data: 16'h1234});
        wr_q.push_back('{addr: 8'h11, data: 16'hABCD});
        done_q.push_back(1'b0);
        issue(1'b1, 1'b1, 8'h10, 16'h1234, 16'hABCD);
        watch(5, nb, nd, nw);
        check("t1_busy_cycles", 32'(nb), 32'(3));
        check("t1_done_count", 32'(nd), 32'(1));
        check("t1_we_cycles", 32'(nw), 32'(2));

        // B only at base 0xFF, ready low for 4 cycles.
        datamem_ready = 1'b0;
        wr_q.push_back('{addr: 8'h00, data: 16'h5A5A});
        done_q.push_back(1'b0);
        issue(1'b0, 1'b1, 8'hFF, 16'h1111, 16'h5A5A);
        B = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_wait_we", 32'(datamem_we), 32'(1));
            check("t2_wait_addr", 32'(datamem_addr), 32'(8'h00));
            check("t2_wait_data", 32'(datamem_in), 32'(16'h5A5A));
        end
        tick();
        datamem_ready = 1'b1;
        watch(4, nb, nd, nw);
        check("t2_busy_cycles", 32'(nb), 32'(2));
        check("t2_done_count", 32'(nd), 32'(1));

        // A only; A changes and start re-pulses during WR_A.
        datamem_ready = 1'b0;
        wr_q.push_back('{addr: 8'h20, data: 16'h1111});
        done_q.push_back(1'b0);
        issue(1'b1, 1'b0, 8'h20, 16'h1111, 16'h2222);
        A = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t3_held_data", 32'(datamem_in), 32'(16'h1111));
        check("t3_held_addr", 32'(datamem_addr), 32'(8'h20));
        tick();
        datamem_ready = 1'b1;
        watch(6, nb, nd, nw);
        check("t3_done_count", 32'(nd), 32'(1));
        check("t3_busy_cycles", 32'(nb), 32'(2));

        // No-op command.
        done_q.push_back(1'b0);
        issue(1'b0, 1'b0, 8'h33, 16'h3333, 16'h4444);
        watch(4, nb, nd, nw);
        check("t4_busy_cycles", 32'(nb), 32'(1));
        check("t4_done_count", 32'(nd), 32'(1));
        check("t4_we_cycles", 32'(nw), 32'(0));

        // Async reset during WR_B.
        datamem_ready = 1'b0;
        issue(1'b0, 1'b1, 8'h50, 16'h0000, 16'h6666);
        @(negedge clk);
        check("t5_we_before_reset", 32'(datamem_we), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        check("t5_we_async_drop", 32'(datamem_we), 32'(0));
        check("t5_busy_async_drop", 32'(busy), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        watch(3, nb, nd, nw);
        check("t5_no_done", 32'(nd), 32'(0));
        check("t5_idle_busy", 32'(nb), 32'(0));
        datamem_ready = 1'b1;
        wr_q.push_back('{addr: 8'h30, data: 16'h0F0F});
        wr_q.push_back('{addr: 8'h31, data: 16'hF0F0});
        done_q.push_back(1'b0);
        issue(1'b1, 1'b1, 8'h30, 16'h0F0F, 16'hF0F0);
        watch(5, nb, nd, nw);
        check("t5_after_busy", 32'(nb), 32'(3));
        check("t5_after_done", 32'(nd), 32'(1));

        // Ready held low in WR_A.
        datamem_ready = 1'b0;
`ifdef STORE_TIMEOUT_EN
        done_q.push_back(1'b1);
        issue(1'b1, 1'b1, 8'h40, 16'h7777, 16'h8888);
        watch(22, nb, nd, nw);
        check("t6_abort_busy", 32'(nb), 32'(MAX_WAIT + 2));
        check("t6_abort_we", 32'(nw), 32'(MAX_WAIT + 1));
        check("t6_abort_done", 32'(nd), 32'(1));
`else
        issue(1'b1, 1'b1, 8'h40, 16'h7777, 16'h8888);
        watch(30, nb, nd, nw);
        check("t6_wait_busy", 32'(nb), 32'(30));
        check("t6_wait_we", 32'(nw), 32'(30));
        check("t6_wait_done", 32'(nd), 32'(0));
        wr_q.push_back('{addr: 8'h40, data: 16'h7777});
        wr_q.push_back('{addr: 8'h41, data: 16'h8888});
        done_q.push_back(1'b0);
        tick();
        datamem_ready = 1'b1;
        watch(5, nb, nd, nw);
        check("t6_recover_done", 32'(nd), 32'(1));
`endif

        check("wr_queue_empty", 32'(wr_q.size()), 32'(0));
        check("done_queue_empty", 32'(done_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
